// File: rtl/lock_loss_monitor.sv
// lock_loss_monitor: debounced QPLL/MMCM lock-loss detector with restart pulse, holdoff, retry limit; LOCK_MON_QPLL_EN adds QPLL_LOCK to lock_ok
module lock_loss_monitor #(
  parameter logic [7:0]  DEBOUNCE  = 8'd40,
  parameter logic [3:0]  RST_PULSE = 4'd8,
  parameter logic [15:0] HOLDOFF   = 16'd4000,
  parameter logic [3:0]  MAX_RETRY = 4'd3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       QPLL_LOCK,
  input  logic       MMCM_LOCK,
  input  logic       CLR_FAULT,
  output logic       RESTART_REQ,
  output logic       LOCK_FAULT,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] MON_STATE
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DEB     = 3'd2,
    S_RESTART = 3'd3,
    S_HOLD    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE) - 16'd1;
  localparam logic [15:0] PULSE_LAST = 16'(RST_PULSE) - 16'd1;
  localparam logic [15:0] HOLD_LAST  = HOLDOFF - 16'd1;
  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  retry_cnt;
  logic [1:0]  m_sync;
  logic        lock_ok;
  always_ff @(posedge CLK or posedge RST)
    if (RST) m_sync <= '0;
    else m_sync <= {m_sync[0], MMCM_LOCK};
`ifdef LOCK_MON_QPLL_EN
  logic [1:0] q_sync;
  always_ff @(posedge CLK or posedge RST)
    if (RST) q_sync <= '0;
    else q_sync <= {q_sync[0], QPLL_LOCK};
  assign lock_ok = m_sync[1] & q_sync[1];
`else
  logic unused_qpll;
  assign unused_qpll = QPLL_LOCK;
  assign lock_ok = m_sync[1];
`endif
  assign MON_STATE = state;
  // cnt is shared: arm-stability, debounce, pulse width and holdoff; each state entry clears it
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      retry_cnt   <= '0;
      RESTART_REQ <= 1'b0;
      LOCK_FAULT  <= 1'b0;
      LOSS_CNT    <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (RUN && lock_ok) begin
            state <= S_ARMED;
            cnt   <= '0;
          end
        S_ARMED:
          if (!RUN) state <= S_IDLE;
          else if (!lock_ok) begin
            state <= S_DEB;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) retry_cnt <= '0;
          else cnt <= cnt + 16'd1;
        S_DEB:
          if (!RUN) state <= S_IDLE;
          else if (lock_ok) begin
            state <= S_ARMED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            LOSS_CNT <= (LOSS_CNT == 8'hff) ? LOSS_CNT : LOSS_CNT + 8'd1;
            if (retry_cnt == MAX_RETRY) begin
              state      <= S_FAULT;
              LOCK_FAULT <= 1'b1;
            end else begin
              retry_cnt   <= retry_cnt + 4'd1;
              state       <= S_RESTART;
              RESTART_REQ <= 1'b1;
              cnt         <= '0;
            end
          end else cnt <= cnt + 16'd1;
        S_RESTART:
          if (cnt == PULSE_LAST) begin
            RESTART_REQ <= 1'b0;
            state       <= S_HOLD;
            cnt         <= '0;
          end else cnt <= cnt + 16'd1;
        S_HOLD:
          if (cnt == HOLD_LAST) state <= S_IDLE;
          else cnt <= cnt + 16'd1;
        S_FAULT: begin
          RESTART_REQ <= 1'b0;
          LOCK_FAULT  <= 1'b1;
          if (CLR_FAULT) state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          RESTART_REQ <= 1'b0;
        end
      endcase
      // placed last so a clear overrides a same-cycle loss count or retry increment
      if (CLR_FAULT) begin
        LOSS_CNT   <= '0;
        retry_cnt  <= '0;
        LOCK_FAULT <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lock_loss_monitor.sv
// tb_lock_loss_monitor: directed checks of debounce, restart pulse, holdoff, retry fault, clear and reset
module tb_lock_loss_monitor;
  logic       CLK = 1'b0;
  logic       RST, RUN, QPLL_LOCK, MMCM_LOCK, CLR_FAULT;
  logic       RESTART_REQ, LOCK_FAULT;
  logic [7:0] LOSS_CNT;
  logic [2:0] MON_STATE;
  int         errors = 0;
  int         checks = 0;
  int         first_req, req_n;
  logic [2:0] st [0:127];

  lock_loss_monitor #(
    .DEBOUNCE(8'd8), .RST_PULSE(4'd8), .HOLDOFF(16'd50), .MAX_RETRY(4'd3)
  ) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .QPLL_LOCK(QPLL_LOCK), .MMCM_LOCK(MMCM_LOCK),
    .CLR_FAULT(CLR_FAULT), .RESTART_REQ(RESTART_REQ), .LOCK_FAULT(LOCK_FAULT),
    .LOSS_CNT(LOSS_CNT), .MON_STATE(MON_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // edge n is the n-th CLK edge after the lock drop; CLR_FAULT is held for edge clr_at
  task automatic run_loss(input bit q, input int low_n, input int edges, input int clr_at);
    first_req = 0;
    req_n     = 0;
    if (q) QPLL_LOCK = 1'b0;
    else MMCM_LOCK = 1'b0;
    for (int n = 1; n <= edges; n++) begin
      CLR_FAULT = (n == clr_at);
      @(posedge CLK);
      #1;
      st[n] = MON_STATE;
      if (RESTART_REQ) begin
        req_n++;
        if (first_req == 0) first_req = n;
      end
      if (n == low_n) begin
        QPLL_LOCK = 1'b1;
        MMCM_LOCK = 1'b1;
      end
    end
    CLR_FAULT = 1'b0;
    QPLL_LOCK = 1'b1;
    MMCM_LOCK = 1'b1;
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1; CLR_FAULT = 1'b0;
    #12;
    check("rst_req", RESTART_REQ, 0);
    check("rst_fault", LOCK_FAULT, 0);
    check("rst_loss", LOSS_CNT, 0);
    check("rst_state", MON_STATE, 0);
    RST = 1'b0;
    RUN = 1'b1;
    cyc(4);
    check("arm_state", MON_STATE, 1);

    run_loss(0, 5, 20, 0);
    check("glitch5_req", req_n, 0);
    check("glitch5_deb", st[5], 2);
    check("glitch5_loss", LOSS_CNT, 0);
    check("glitch5_state", MON_STATE, 1);
    run_loss(0, 7, 20, 0);
    check("glitch7_req", req_n, 0);
    check("glitch7_loss", LOSS_CNT, 0);
    check("glitch7_state", MON_STATE, 1);

    run_loss(0, 20, 72, 0);
    check("loss_first_req", first_req, 11);
    check("loss_req_len", req_n, 8);
    check("loss_cnt", LOSS_CNT, 1);
    check("loss_st3", st[3], 2);
    check("loss_st10", st[10], 2);
    check("loss_st11", st[11], 3);
    check("loss_st18", st[18], 3);
    check("loss_st19", st[19], 4);
    check("loss_st68", st[68], 4);
    check("loss_st69", st[69], 0);
    check("loss_st70", st[70], 1);
    CLR_FAULT = 1'b1;
    cyc(1);
    CLR_FAULT = 1'b0;
    check("clr_loss", LOSS_CNT, 0);
    check("clr_armed", MON_STATE, 1);

    for (int i = 0; i < 4; i++) begin
      run_loss(0, 20, 72, 0);
      if (i < 3) begin
        check("retry_req_len", req_n, 8);
        check("retry_loss", LOSS_CNT, i + 1);
      end else begin
        check("fault_req", req_n, 0);
        check("fault_state", MON_STATE, 5);
        check("fault_flag", LOCK_FAULT, 1);
        check("fault_loss", LOSS_CNT, 4);
      end
    end
    CLR_FAULT = 1'b1;
    cyc(1);
    CLR_FAULT = 1'b0;
    check("fclr_state", MON_STATE, 0);
    check("fclr_loss", LOSS_CNT, 0);
    check("fclr_flag", LOCK_FAULT, 0);
    cyc(1);
    check("fclr_rearm", MON_STATE, 1);

    run_loss(0, 20, 12, 11);
    check("coinc_first_req", first_req, 11);
    check("coinc_state", st[11], 3);
    check("coinc_loss", LOSS_CNT, 0);
    cyc(60);
    check("coinc_rearm", MON_STATE, 1);

`ifdef LOCK_MON_QPLL_EN
    run_loss(1, 20, 72, 0);
    check("qpll_first_req", first_req, 11);
    check("qpll_req_len", req_n, 8);
    check("qpll_loss", LOSS_CNT, 1);
`else
    run_loss(1, 100, 104, 0);
    check("qpll_ign_req", req_n, 0);
    check("qpll_ign_loss", LOSS_CNT, 0);
    check("qpll_ign_state", MON_STATE, 1);
`endif

    run_loss(0, 20, 14, 0);
    check("mid_req_on", RESTART_REQ, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_req", RESTART_REQ, 0);
    check("mid_rst_fault", LOCK_FAULT, 0);
    check("mid_rst_loss", LOSS_CNT, 0);
    check("mid_rst_state", MON_STATE, 0);
    RUN = 1'b1;
    #3;
    RST = 1'b0;
    cyc(4);
    check("post_rst_arm", MON_STATE, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
